// File: rtl/l1_port_arbiter_if.sv
// L1 AXI master bundle (32-bit addr/data, single ID) between the port arbiter and the tile L1 slave.
// Handshakes: a transfer happens on a rising clk edge where VALID and READY are both high; a source
// holds VALID and its payload stable until that edge, and READY may change freely.
interface l1_port_arbiter_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        rlast;
  logic        rid;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic        bid;

  modport master (
    output arvalid, araddr, arlen, arsize, rready,
    output awvalid, awaddr, awlen, awsize, wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rlast, rid, awready, wready, bvalid, bid
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, rready,
    input  awvalid, awaddr, awlen, awsize, wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rlast, rid, awready, wready, bvalid, bid
  );
endinterface

// File: rtl/l1_port_arbiter.sv
// l1_port_arbiter: round-robin sharing of one L1 AXI master among N_REQ task units, in-order owner FIFOs.
// Define L1_ARB_PERF_EN to enable the saturating perf_rd_stall counter; otherwise it is tied to 0.
module l1_port_arbiter #(
  parameter int N_REQ       = 4,
  parameter int OUTSTANDING = 4,
  parameter int IDX_W       = $clog2(N_REQ)
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [N_REQ-1:0]                 req_arvalid,
  input  logic [N_REQ*32-1:0]              req_araddr,
  input  logic [N_REQ*8-1:0]               req_arlen,
  input  logic [N_REQ*3-1:0]               req_arsize,
  output logic [N_REQ-1:0]                 req_arready,
  output logic [N_REQ-1:0]                 req_rvalid,
  output logic [31:0]                      req_rdata,
  output logic                             req_rlast,
  input  logic [N_REQ-1:0]                 req_rready,
  input  logic [N_REQ-1:0]                 req_awvalid,
  input  logic [N_REQ*32-1:0]              req_awaddr,
  input  logic [N_REQ*8-1:0]               req_awlen,
  input  logic [N_REQ*3-1:0]               req_awsize,
  output logic [N_REQ-1:0]                 req_awready,
  input  logic [N_REQ-1:0]                 req_wvalid,
  input  logic [N_REQ*32-1:0]              req_wdata,
  input  logic [N_REQ*4-1:0]               req_wstrb,
  input  logic [N_REQ-1:0]                 req_wlast,
  output logic [N_REQ-1:0]                 req_wready,
  output logic [N_REQ-1:0]                 req_bvalid,
  input  logic [N_REQ-1:0]                 req_bready,
  l1_port_arbiter_if.master                m_axi_l1_V,
  output logic [31:0]                      perf_rd_stall,
  output logic                             dbg_ar_state,
  output logic                             dbg_aw_state,
  output logic [IDX_W-1:0]                 dbg_rd_ptr,
  output logic [IDX_W-1:0]                 dbg_wr_ptr,
  output logic [$clog2(OUTSTANDING+1)-1:0] dbg_rd_count,
  output logic [$clog2(OUTSTANDING+1)-1:0] dbg_wr_count
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_HOLD = 1'b1;
  localparam logic [0:0] AW_IDLE = 1'b0;
  localparam logic [0:0] AW_HOLD = 1'b1;

  function automatic logic [IDX_W-1:0] circ(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [0:0]       ar_state, aw_state;
  logic [IDX_W-1:0] rd_ptr, wr_ptr;
  logic [IDX_W-1:0] ar_hold_idx, aw_hold_idx;
  logic [IDX_W-1:0] ar_win, aw_win;
  logic             ar_sel, aw_sel, ar_hs, aw_hs;

  logic [IDX_W-1:0] rd_own [OUTSTANDING];
  logic [IDX_W-1:0] wr_own [OUTSTANDING];
  logic [PTR_W-1:0] rd_wp, rd_rp, wr_wp, wr_rp;
  logic [CNT_W-1:0] rd_count, wr_count;
  logic             rd_full, rd_empty, wr_full, wr_empty;
  logic [IDX_W-1:0] rd_head, wr_head;
  logic             r_rready, r_pop, b_bready, b_pop;

  assign rd_full  = (rd_count == CNT_W'(OUTSTANDING));
  assign rd_empty = (rd_count == '0);
  assign wr_full  = (wr_count == CNT_W'(OUTSTANDING));
  assign wr_empty = (wr_count == '0);
  assign rd_head  = rd_own[rd_rp];
  assign wr_head  = wr_own[wr_rp];

  // Scanning from the far end lets the lowest circular offset from the pointer win.
  always_comb begin
    ar_win = ar_hold_idx;
    ar_sel = 1'b0;
    if (ar_state == AR_HOLD) begin
      ar_sel = req_arvalid[ar_hold_idx];
    end else if (!rd_full) begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (req_arvalid[circ(rd_ptr, k)]) begin
          ar_win = circ(rd_ptr, k);
          ar_sel = 1'b1;
        end
      end
    end
  end

  always_comb begin
    aw_win = aw_hold_idx;
    aw_sel = 1'b0;
    if (aw_state == AW_HOLD) begin
      aw_sel = req_awvalid[aw_hold_idx] & req_wvalid[aw_hold_idx];
    end else if (!wr_full) begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (req_awvalid[circ(wr_ptr, k)] && req_wvalid[circ(wr_ptr, k)]) begin
          aw_win = circ(wr_ptr, k);
          aw_sel = 1'b1;
        end
      end
    end
  end

  assign ar_hs = ar_sel & m_axi_l1_V.arready;
  // AW and W are accepted only together so a write never splits across owners.
  assign aw_hs = aw_sel & m_axi_l1_V.awready & m_axi_l1_V.wready;

  assign m_axi_l1_V.arvalid = ar_sel;
  assign m_axi_l1_V.araddr  = req_araddr[int'(ar_win)*32 +: 32];
  assign m_axi_l1_V.arlen   = req_arlen[int'(ar_win)*8 +: 8];
  assign m_axi_l1_V.arsize  = req_arsize[int'(ar_win)*3 +: 3];

  assign m_axi_l1_V.awvalid = aw_sel;
  assign m_axi_l1_V.awaddr  = req_awaddr[int'(aw_win)*32 +: 32];
  assign m_axi_l1_V.awlen   = req_awlen[int'(aw_win)*8 +: 8];
  assign m_axi_l1_V.awsize  = req_awsize[int'(aw_win)*3 +: 3];
  assign m_axi_l1_V.wvalid  = aw_sel;
  assign m_axi_l1_V.wdata   = req_wdata[int'(aw_win)*32 +: 32];
  assign m_axi_l1_V.wstrb   = req_wstrb[int'(aw_win)*4 +: 4];
  assign m_axi_l1_V.wlast   = req_wlast[aw_win];

  always_comb begin
    req_arready = '0;
    req_awready = '0;
    if (ar_sel) req_arready[ar_win] = m_axi_l1_V.arready;
    if (aw_sel) req_awready[aw_win] = m_axi_l1_V.awready & m_axi_l1_V.wready;
  end
  assign req_wready = req_awready;

  // Responses come back in issue order, so the FIFO head always names the owner.
  assign r_rready           = !rd_empty && req_rready[rd_head];
  assign b_bready           = !wr_empty && req_bready[wr_head];
  assign m_axi_l1_V.rready  = r_rready;
  assign m_axi_l1_V.bready  = b_bready;
  assign r_pop              = m_axi_l1_V.rvalid & r_rready & m_axi_l1_V.rlast;
  assign b_pop              = m_axi_l1_V.bvalid & b_bready;
  assign req_rdata          = m_axi_l1_V.rdata;
  assign req_rlast          = m_axi_l1_V.rlast;

  always_comb begin
    req_rvalid = '0;
    req_bvalid = '0;
    if (!rd_empty) req_rvalid[rd_head] = m_axi_l1_V.rvalid;
    if (!wr_empty) req_bvalid[wr_head] = m_axi_l1_V.bvalid;
  end

  always_ff @(posedge ap_clk) begin
    if (ar_hs) rd_own[rd_wp] <= ar_win;
    if (aw_hs) wr_own[wr_wp] <= aw_win;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ar_state    <= AR_IDLE;
      ar_hold_idx <= '0;
      rd_ptr      <= '0;
      rd_wp       <= '0;
      rd_rp       <= '0;
      rd_count    <= '0;
    end else begin
      if (ar_hs) begin
        ar_state <= AR_IDLE;
        rd_ptr   <= circ(ar_win, 1);
        rd_wp    <= ptr_inc(rd_wp);
      end else if (ar_sel) begin
        ar_state    <= AR_HOLD;
        ar_hold_idx <= ar_win;
      end
      if (r_pop) rd_rp <= ptr_inc(rd_rp);
      if (ar_hs && !r_pop) rd_count <= rd_count + CNT_W'(1);
      else if (!ar_hs && r_pop) rd_count <= rd_count - CNT_W'(1);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      aw_state    <= AW_IDLE;
      aw_hold_idx <= '0;
      wr_ptr      <= '0;
      wr_wp       <= '0;
      wr_rp       <= '0;
      wr_count    <= '0;
    end else begin
      if (aw_hs) begin
        aw_state <= AW_IDLE;
        wr_ptr   <= circ(aw_win, 1);
        wr_wp    <= ptr_inc(wr_wp);
      end else if (aw_sel) begin
        aw_state    <= AW_HOLD;
        aw_hold_idx <= aw_win;
      end
      if (b_pop) wr_rp <= ptr_inc(wr_rp);
      if (aw_hs && !b_pop) wr_count <= wr_count + CNT_W'(1);
      else if (!aw_hs && b_pop) wr_count <= wr_count - CNT_W'(1);
    end
  end

`ifdef L1_ARB_PERF_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      stall_cnt <= '0;
    end else if ((|req_arvalid) && !ar_hs && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
  assign perf_rd_stall = stall_cnt;
`else
  assign perf_rd_stall = 32'd0;
`endif

  // Single-ID, in-order slave: returned IDs carry no information.
  logic unused_ids;
  assign unused_ids = m_axi_l1_V.rid ^ m_axi_l1_V.bid;

  assign dbg_ar_state = ar_state;
  assign dbg_aw_state = aw_state;
  assign dbg_rd_ptr   = rd_ptr;
  assign dbg_wr_ptr   = wr_ptr;
  assign dbg_rd_count = rd_count;
  assign dbg_wr_count = wr_count;

endmodule

// File: tb/tb_l1_port_arbiter.sv
// Randomized bench for l1_port_arbiter: bench-side requesters and L1 slave, a transaction-level
// round-robin/owner-queue reference model, and per-requester read-data scoreboards.
module tb_l1_port_arbiter;

  localparam int N_REQ       = 4;
  localparam int OUTSTANDING = 4;
  localparam int IDX_W       = 2;
  localparam int CNT_W       = 3;

  logic                  ap_clk = 1'b0;
  logic                  ap_rst;
  logic [N_REQ-1:0]      req_arvalid, req_arready, req_rvalid, req_rready;
  logic [N_REQ*32-1:0]   req_araddr, req_awaddr, req_wdata;
  logic [N_REQ*8-1:0]    req_arlen, req_awlen;
  logic [N_REQ*3-1:0]    req_arsize, req_awsize;
  logic [N_REQ*4-1:0]    req_wstrb;
  logic [31:0]           req_rdata;
  logic                  req_rlast;
  logic [N_REQ-1:0]      req_awvalid, req_awready, req_wvalid, req_wlast, req_wready;
  logic [N_REQ-1:0]      req_bvalid, req_bready;
  logic [31:0]           perf_rd_stall;
  logic                  dbg_ar_state, dbg_aw_state;
  logic [IDX_W-1:0]      dbg_rd_ptr, dbg_wr_ptr;
  logic [CNT_W-1:0]      dbg_rd_count, dbg_wr_count;

  l1_port_arbiter_if m_axi_l1_V();

  l1_port_arbiter #(.N_REQ(N_REQ), .OUTSTANDING(OUTSTANDING), .IDX_W(IDX_W)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_arsize(req_arsize), .req_arready(req_arready),
    .req_rvalid(req_rvalid), .req_rdata(req_rdata), .req_rlast(req_rlast), .req_rready(req_rready),
    .req_awvalid(req_awvalid), .req_awaddr(req_awaddr), .req_awlen(req_awlen),
    .req_awsize(req_awsize), .req_awready(req_awready),
    .req_wvalid(req_wvalid), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_wlast(req_wlast), .req_wready(req_wready),
    .req_bvalid(req_bvalid), .req_bready(req_bready),
    .m_axi_l1_V(m_axi_l1_V),
    .perf_rd_stall(perf_rd_stall),
    .dbg_ar_state(dbg_ar_state), .dbg_aw_state(dbg_aw_state),
    .dbg_rd_ptr(dbg_rd_ptr), .dbg_wr_ptr(dbg_wr_ptr),
    .dbg_rd_count(dbg_rd_count), .dbg_wr_count(dbg_wr_count)
  );

  // ---------------- clock ----------------
  always #5 ap_clk = ~ap_clk;

  // ---------------- scoreboard / counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Per-requester expected read beats {rlast, rdata}, pushed when the requester's AR is accepted.
  logic [32:0] exp_q[N_REQ][$];

  // ---------------- stimulus knobs (percent) ----------------
  int p_ar, p_arready, p_rv, p_rready, p_aw, p_w, p_awready, p_wready, p_bv, p_bready;

  function automatic bit chance(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  // ---------------- bench requesters and slave ----------------
  bit          ar_pend [N_REQ];
  logic [31:0] ar_addr [N_REQ];
  logic [7:0]  ar_len  [N_REQ];
  bit          aw_pend [N_REQ];
  bit          w_up    [N_REQ];
  logic [31:0] aw_addr [N_REQ];
  logic [31:0] w_data  [N_REQ];
  logic [3:0]  w_strb  [N_REQ];

  logic [31:0] s_addr_q[$];
  logic [7:0]  s_len_q[$];
  int          s_beat;
  bit          r_busy;
  int          b_cnt;
  bit          b_busy;

  // ---------------- reference model ----------------
  int          ar_held, aw_held;
  int          rd_next, wr_next;
  int          rd_own_q[$];
  int          wr_own_q[$];
  logic [31:0] perf_exp;

  task automatic clear_bench_state();
    for (int i = 0; i < N_REQ; i++) begin
      ar_pend[i] = 0; aw_pend[i] = 0; w_up[i] = 0;
      ar_addr[i] = '0; ar_len[i] = '0; aw_addr[i] = '0; w_data[i] = '0; w_strb[i] = '0;
      exp_q[i].delete();
    end
    s_addr_q.delete(); s_len_q.delete();
    s_beat = 0; r_busy = 0; b_cnt = 0; b_busy = 0;
    ar_held = -1; aw_held = -1; rd_next = 0; wr_next = 0;
    rd_own_q.delete(); wr_own_q.delete();
    perf_exp = '0;
  endtask

  task automatic drive_idle();
    req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_arsize = '0; req_rready = '0;
    req_awvalid = '0; req_awaddr = '0; req_awlen = '0; req_awsize = '0;
    req_wvalid = '0; req_wdata = '0; req_wstrb = '0; req_wlast = '0; req_bready = '0;
    m_axi_l1_V.arready = 0; m_axi_l1_V.rvalid = 0; m_axi_l1_V.rdata = '0; m_axi_l1_V.rlast = 0;
    m_axi_l1_V.rid = 0; m_axi_l1_V.awready = 0; m_axi_l1_V.wready = 0;
    m_axi_l1_V.bvalid = 0; m_axi_l1_V.bid = 0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N_REQ; i++) begin
      if (!ar_pend[i] && chance(p_ar)) begin
        ar_pend[i] = 1;
        ar_addr[i] = $urandom & 32'hFFFF_FFFC;
        ar_len[i]  = 8'($urandom_range(3, 0));
      end
      req_arvalid[i]           = ar_pend[i];
      req_araddr[i*32 +: 32]   = ar_addr[i];
      req_arlen[i*8 +: 8]      = ar_len[i];
      req_arsize[i*3 +: 3]     = 3'd2;
      req_rready[i]            = chance(p_rready);
      if (!aw_pend[i] && chance(p_aw)) begin
        aw_pend[i] = 1;
        aw_addr[i] = $urandom & 32'hFFFF_FFFC;
        w_data[i]  = $urandom;
        w_strb[i]  = 4'($urandom_range(15, 1));
        w_up[i]    = chance(50);
      end else if (aw_pend[i] && !w_up[i] && chance(p_w)) begin
        w_up[i] = 1;
      end
      req_awvalid[i]           = aw_pend[i];
      req_wvalid[i]            = aw_pend[i] & w_up[i];
      req_awaddr[i*32 +: 32]   = aw_addr[i];
      req_awlen[i*8 +: 8]      = 8'd0;
      req_awsize[i*3 +: 3]     = 3'd2;
      req_wdata[i*32 +: 32]    = w_data[i];
      req_wstrb[i*4 +: 4]      = w_strb[i];
      req_wlast[i]             = 1'b1;
      req_bready[i]            = chance(p_bready);
    end
    m_axi_l1_V.arready = chance(p_arready);
    m_axi_l1_V.awready = chance(p_awready);
    m_axi_l1_V.wready  = chance(p_wready);
    if (!r_busy && s_addr_q.size() > 0 && chance(p_rv)) r_busy = 1;
    m_axi_l1_V.rvalid = r_busy;
    if (r_busy) begin
      m_axi_l1_V.rdata = s_addr_q[0] + 32'(s_beat * 4);
      m_axi_l1_V.rlast = (s_beat == int'(s_len_q[0]));
    end else begin
      m_axi_l1_V.rdata = $urandom;
      m_axi_l1_V.rlast = chance(50);
    end
    if (!b_busy && b_cnt > 0 && chance(p_bv)) b_busy = 1;
    m_axi_l1_V.bvalid = b_busy;
  endtask

  // Compare DUT outputs with the model for this cycle, then advance the model past the next edge.
  task automatic check_and_update();
    int ar_w, aw_w, ro, wo;
    bit ar_hs, aw_hs, r_hs, b_hs, e_rready, e_bready;
    logic [N_REQ-1:0] e_vec;

    check("rd_ptr", dbg_rd_ptr, rd_next);
    check("wr_ptr", dbg_wr_ptr, wr_next);
    check("rd_count", dbg_rd_count, rd_own_q.size());
    check("wr_count", dbg_wr_count, wr_own_q.size());

    ar_w = -1;
    if (ar_held >= 0) ar_w = ar_held;
    else if (rd_own_q.size() < OUTSTANDING)
      for (int k = 0; k < N_REQ; k++)
        if (ar_w < 0 && req_arvalid[(rd_next + k) % N_REQ]) ar_w = (rd_next + k) % N_REQ;
    ar_hs = (ar_w >= 0) && m_axi_l1_V.arready;
    check("ar_valid", m_axi_l1_V.arvalid, ar_w >= 0);
    if (ar_w >= 0) begin
      check("ar_addr", m_axi_l1_V.araddr, ar_addr[ar_w]);
      check("ar_len", m_axi_l1_V.arlen, ar_len[ar_w]);
      check("ar_size", m_axi_l1_V.arsize, 3'd2);
    end
    e_vec = '0;
    if (ar_hs) e_vec[ar_w] = 1'b1;
    check("ar_ready_vec", req_arready, e_vec);

    ro = (rd_own_q.size() > 0) ? rd_own_q[0] : -1;
    e_rready = (ro >= 0) && req_rready[ro];
    check("r_ready", m_axi_l1_V.rready, e_rready);
    e_vec = '0;
    if (ro >= 0 && m_axi_l1_V.rvalid) e_vec[ro] = 1'b1;
    check("r_valid_vec", req_rvalid, e_vec);
    r_hs = m_axi_l1_V.rvalid && e_rready;
    if (r_hs && exp_q[ro].size() > 0) check("r_beat", {req_rlast, req_rdata}, exp_q[ro].pop_front());

    aw_w = -1;
    if (aw_held >= 0) aw_w = aw_held;
    else if (wr_own_q.size() < OUTSTANDING)
      for (int k = 0; k < N_REQ; k++)
        if (aw_w < 0 && req_awvalid[(wr_next + k) % N_REQ] && req_wvalid[(wr_next + k) % N_REQ])
          aw_w = (wr_next + k) % N_REQ;
    aw_hs = (aw_w >= 0) && m_axi_l1_V.awready && m_axi_l1_V.wready;
    check("aw_valid", m_axi_l1_V.awvalid, aw_w >= 0);
    check("w_valid", m_axi_l1_V.wvalid, aw_w >= 0);
    if (aw_w >= 0) begin
      check("aw_addr", m_axi_l1_V.awaddr, aw_addr[aw_w]);
      check("w_data", m_axi_l1_V.wdata, w_data[aw_w]);
      check("w_strb", m_axi_l1_V.wstrb, w_strb[aw_w]);
      check("w_last", m_axi_l1_V.wlast, 1'b1);
    end
    e_vec = '0;
    if (aw_hs) e_vec[aw_w] = 1'b1;
    check("aw_ready_vec", req_awready, e_vec);
    check("w_ready_vec", req_wready, e_vec);

    wo = (wr_own_q.size() > 0) ? wr_own_q[0] : -1;
    e_bready = (wo >= 0) && req_bready[wo];
    check("b_ready", m_axi_l1_V.bready, e_bready);
    e_vec = '0;
    if (wo >= 0 && m_axi_l1_V.bvalid) e_vec[wo] = 1'b1;
    check("b_valid_vec", req_bvalid, e_vec);
    b_hs = m_axi_l1_V.bvalid && e_bready;

`ifdef L1_ARB_PERF_EN
    check("perf_rd_stall", perf_rd_stall, perf_exp);
`else
    check("perf_rd_stall", perf_rd_stall, 32'd0);
`endif
    if ((|req_arvalid) && !ar_hs && perf_exp != 32'hFFFF_FFFF) perf_exp = perf_exp + 32'd1;

    if (ar_hs) begin
      rd_own_q.push_back(ar_w);
      rd_next = (ar_w + 1) % N_REQ;
      ar_held = -1;
      ar_pend[ar_w] = 0;
      s_addr_q.push_back(ar_addr[ar_w]);
      s_len_q.push_back(ar_len[ar_w]);
      for (int b = 0; b <= int'(ar_len[ar_w]); b++)
        exp_q[ar_w].push_back({1'(b == int'(ar_len[ar_w])), ar_addr[ar_w] + 32'(b * 4)});
    end else if (ar_w >= 0) begin
      ar_held = ar_w;
    end
    if (r_hs) begin
      r_busy = 0;
      if (s_beat == int'(s_len_q[0])) begin
        s_addr_q.pop_front();
        s_len_q.pop_front();
        s_beat = 0;
        rd_own_q.pop_front();
      end else begin
        s_beat++;
      end
    end

    if (aw_hs) begin
      wr_own_q.push_back(aw_w);
      wr_next = (aw_w + 1) % N_REQ;
      aw_held = -1;
      aw_pend[aw_w] = 0;
      w_up[aw_w] = 0;
      b_cnt++;
    end else if (aw_w >= 0) begin
      aw_held = aw_w;
    end
    if (b_hs) begin
      b_busy = 0;
      b_cnt--;
      wr_own_q.pop_front();
    end
  endtask

  task automatic run_phase(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge ap_clk); #1;
      drive_inputs();
      @(negedge ap_clk);
      check_and_update();
    end
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge ap_clk); #1;
    ap_rst = 1'b1;
    clear_bench_state();
    drive_idle();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge ap_clk);
      check("rst_ar_ready", req_arready, '0);
      check("rst_aw_ready", req_awready, '0);
      check("rst_r_valid", req_rvalid, '0);
      check("rst_b_valid", req_bvalid, '0);
      check("rst_m_valids", {m_axi_l1_V.arvalid, m_axi_l1_V.awvalid, m_axi_l1_V.wvalid}, 3'b000);
      check("rst_m_readys", {m_axi_l1_V.rready, m_axi_l1_V.bready}, 2'b00);
      @(posedge ap_clk); #1;
    end
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check_and_update();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    ap_rst = 1'b1;
    drive_idle();
    clear_bench_state();
    do_reset(3);

    // Address channels always ready: grants rotate one requester per cycle.
    p_ar = 90; p_arready = 100; p_rv = 80; p_rready = 90;
    p_aw = 60; p_w = 70; p_awready = 100; p_wready = 100; p_bv = 80; p_bready = 90;
    run_phase(1500);

    // Address backpressure: grants sit in the hold states while others request.
    p_arready = 15; p_awready = 30; p_wready = 30;
    run_phase(1500);

    // Slow returns: owner FIFOs fill and further requests stall.
    p_arready = 80; p_awready = 80; p_wready = 80;
    p_rv = 10; p_rready = 40; p_bv = 10; p_bready = 40;
    run_phase(1500);

    // Everything at medium rates.
    p_ar = 50; p_arready = 50; p_rv = 50; p_rready = 50;
    p_aw = 50; p_w = 50; p_awready = 50; p_wready = 50; p_bv = 50; p_bready = 50;
    run_phase(1500);

    // Reset with transactions in flight, then resume traffic.
    do_reset(1);
    run_phase(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
